// File: rtl/mux_scan_pkg.sv
// Shared types and constants for the 4:1 mux scan sequencer.
// Channel count, select width and the scan FSM state encoding live here.
package mux_scan_pkg;

  localparam int unsigned N_CH  = 4;
  localparam int unsigned SEL_W = 2;

  typedef logic [SEL_W-1:0] ch_idx_t;

  typedef enum logic [1:0] {
    S_IDLE,
    S_SETTLE,
    S_SAMPLE,
    S_DONE
  } state_e;

endpackage

// File: rtl/mux_scan_next_ch.sv
// Combinational next-enabled-channel finder: lowest set mask bit when starting,
// otherwise the lowest set bit strictly above the current channel.
module mux_scan_next_ch
  import mux_scan_pkg::*;
(
  input  logic [N_CH-1:0] mask_i,
  input  ch_idx_t         cur_i,
  input  logic            from_start_i,
  output ch_idx_t         nxt_o,
  output logic            found_o
);

  // Walk downwards so the last qualifying hit is the lowest index.
  always_comb begin
    nxt_o   = '0;
    found_o = 1'b0;
    for (int unsigned k = N_CH; k > 0; k--) begin
      if (mask_i[k-1] && (from_start_i || ((k - 1) > 32'(cur_i)))) begin
        nxt_o   = ch_idx_t'(k - 1);
        found_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mux_scan_ctrl.sv
// Scan sequencer around a 4:1 mux: steps the selects over enabled channels,
// waits SETTLE cycles on each, samples f, and reports a 4-bit snapshot.
module mux_scan_ctrl
  import mux_scan_pkg::*;
#(
  parameter int unsigned SETTLE = 2,
  parameter int unsigned CNT_W  = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic            abort,
  input  logic [N_CH-1:0] ch_mask,
  input  logic            f,
  output logic            s0,
  output logic            s1,
  output logic            busy,
  output logic            done,
  output logic [N_CH-1:0] sample,
  output logic [N_CH-1:0] valid_mask
);

  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(SETTLE - 1);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  ch_idx_t           sel_q, sel_d;
  logic [N_CH-1:0]   sample_q, sample_d;
  logic [N_CH-1:0]   vmask_q, vmask_d;

  logic [N_CH-1:0]   nc_mask;
  logic              nc_from_start;
  ch_idx_t           nc_nxt;
  logic              nc_found;

  // In IDLE the live ch_mask is searched; mid-scan the latched copy is used.
  assign nc_from_start = (state_q == S_IDLE);
  assign nc_mask       = nc_from_start ? ch_mask : vmask_q;

  mux_scan_next_ch u_next_ch (
    .mask_i       (nc_mask),
    .cur_i        (sel_q),
    .from_start_i (nc_from_start),
    .nxt_o        (nc_nxt),
    .found_o      (nc_found)
  );

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    sel_d    = sel_q;
    sample_d = sample_q;
    vmask_d  = vmask_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          sample_d = '0;
          vmask_d  = ch_mask;
          if (nc_found) begin
            sel_d   = nc_nxt;
            cnt_d   = CNT_LOAD;
            state_d = S_SETTLE;
          end else begin
            state_d = S_DONE;
          end
        end
      end

      S_SETTLE: begin
        if (abort) begin
          sel_d   = '0;
          vmask_d = '0;
          state_d = S_IDLE;
        end else if (cnt_q == '0) begin
          state_d = S_SAMPLE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end

      S_SAMPLE: begin
        if (abort) begin
          sel_d   = '0;
          vmask_d = '0;
          state_d = S_IDLE;
        end else begin
          sample_d[sel_q] = f;
          if (nc_found) begin
            sel_d   = nc_nxt;
            cnt_d   = CNT_LOAD;
            state_d = S_SETTLE;
          end else begin
            sel_d   = '0;
            state_d = S_DONE;
          end
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        sel_d   = '0;
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      sel_q    <= '0;
      sample_q <= '0;
      vmask_q  <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      sel_q    <= sel_d;
      sample_q <= sample_d;
      vmask_q  <= vmask_d;
    end
  end

  assign s0         = sel_q[0];
  assign s1         = sel_q[1];
  assign busy       = (state_q == S_SETTLE) || (state_q == S_SAMPLE);
  assign done       = (state_q == S_DONE);
  assign sample     = sample_q;
  assign valid_mask = vmask_q;

endmodule

// File: tb/tb_mux_scan_ctrl.sv
// Self-checking bench for mux_scan_ctrl: table-driven scans with a result
// scoreboard, plus hand-written abort and mid-scan reset sequences.
module tb_mux_scan_ctrl;

  localparam int unsigned SETTLE = 2;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic [3:0] ch_mask = '0;
  logic [3:0] i_vec = '0;
  logic       f;
  logic       s0, s1, busy, done;
  logic [3:0] sample, valid_mask;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [3:0] mask;
    logic [3:0] ins;
    int         ex1;
    int         ex2;
    logic       ab;
    logic [3:0] exp_sample;
    logic [3:0] exp_vmask;
    int         exp_done;
  } vec_t;

  typedef struct {
    logic [3:0] sample;
    logic [3:0] vmask;
    int         done_cyc;
  } exp_t;

  exp_t sb[$];
  vec_t tbl[7];

  // Behavioural 4:1 mux feeding the sequencer.
  assign f = i_vec[{s1, s0}];

  mux_scan_ctrl #(.SETTLE(SETTLE), .CNT_W(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .abort      (abort),
    .ch_mask    (ch_mask),
    .f          (f),
    .s0         (s0),
    .s1         (s1),
    .busy       (busy),
    .done       (done),
    .sample     (sample),
    .valid_mask (valid_mask)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_scan(input vec_t v);
    exp_t e;
    int   cyc;
    bit   seen;
    int   chans[$];
    int   exp_s;
    for (int k = 0; k < 4; k++) if (v.mask[k]) chans.push_back(k);
    i_vec   = v.ins;
    ch_mask = v.mask;
    start   = 1'b1;
    abort   = v.ab;
    e.sample   = v.exp_sample;
    e.vmask    = v.exp_vmask;
    e.done_cyc = v.exp_done;
    sb.push_back(e);
    step();
    start   = 1'b0;
    abort   = 1'b0;
    ch_mask = ~v.mask;
    cyc  = 1;
    seen = 0;
    while (cyc <= v.exp_done + 2) begin
      start = (cyc == v.ex1) || (cyc == v.ex2);
      exp_s = (cyc < v.exp_done) ? chans[(cyc - 1) / (SETTLE + 1)] : 0;
      chk("sel", 32'({s1, s0}), 32'(exp_s));
      chk("busy", 32'(busy), 32'(cyc < v.exp_done));
      if (done === 1'b1) begin
        if (seen || sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL extra_done: got done at cycle %0d expected none", cyc);
        end else begin
          e = sb.pop_front();
          chk("done_cyc", 32'(cyc), 32'(e.done_cyc));
          chk("sample", 32'(sample), 32'(e.sample));
          chk("valid_mask", 32'(valid_mask), 32'(e.vmask));
          seen = 1;
        end
      end
      step();
      cyc++;
    end
    start = 1'b0;
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL done_missing: got no done expected cycle %0d", v.exp_done);
      void'(sb.pop_front());
    end
    chk("sample_hold", 32'(sample), 32'(v.exp_sample));
    chk("vmask_hold", 32'(valid_mask), 32'(v.exp_vmask));
  endtask

  initial begin
    tbl[0] = '{4'b1111, 4'b1101, 0, 0,  1'b0, 4'b1101, 4'b1111, 13};
    tbl[1] = '{4'b1010, 4'b0110, 0, 0,  1'b0, 4'b0010, 4'b1010, 7};
    tbl[2] = '{4'b0000, 4'b1111, 0, 0,  1'b0, 4'b0000, 4'b0000, 1};
    tbl[3] = '{4'b1111, 4'b1101, 3, 13, 1'b0, 4'b1101, 4'b1111, 13};
    tbl[4] = '{4'b0100, 4'b0100, 0, 0,  1'b0, 4'b0100, 4'b0100, 4};
    tbl[5] = '{4'b1001, 4'b1001, 0, 0,  1'b1, 4'b1001, 4'b1001, 7};
    tbl[6] = '{4'b1111, 4'b0000, 0, 0,  1'b0, 4'b0000, 4'b1111, 13};

    #12;
    chk("rst_sel", 32'({s1, s0}), 32'd0);
    chk("rst_busy_done", 32'({busy, done}), 32'd0);
    chk("rst_sample", 32'(sample), 32'd0);
    chk("rst_vmask", 32'(valid_mask), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    step();

    foreach (tbl[i]) do_scan(tbl[i]);

    // Abort while channel 1 is settling.
    i_vec = 4'b1101; ch_mask = 4'b1111; start = 1'b1;
    step();
    start = 1'b0;
    for (int c = 1; c < 5; c++) step();
    chk("abort_pre_sel", 32'({s1, s0}), 32'd1);
    abort = 1'b1;
    step();
    abort = 1'b0;
    chk("abort_sel", 32'({s1, s0}), 32'd0);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_vmask", 32'(valid_mask), 32'd0);
    chk("abort_sample", 32'(sample), 32'b0001);
    for (int c = 0; c < 15; c++) begin
      chk("abort_no_done", 32'(done), 32'd0);
      step();
    end
    do_scan(tbl[0]);

    // Asynchronous reset in the middle of a scan.
    i_vec = 4'b1101; ch_mask = 4'b1111; start = 1'b1;
    step();
    start = 1'b0;
    for (int c = 1; c < 8; c++) step();
    chk("prerst_sel", 32'({s1, s0}), 32'd2);
    chk("prerst_sample", 32'(sample), 32'b0001);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_sel", 32'({s1, s0}), 32'd0);
    chk("midrst_busy_done", 32'({busy, done}), 32'd0);
    chk("midrst_sample", 32'(sample), 32'd0);
    chk("midrst_vmask", 32'(valid_mask), 32'd0);
    step();
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 15; c++) begin
      step();
      chk("postrst_no_done", 32'(done), 32'd0);
    end
    do_scan(tbl[0]);

    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mux_scan_ctrl.md
Name: mux_scan_ctrl

Overview:
- Sequencer that sits around the 4:1 mux primitive: drives its selects upstream and consumes its output `f` downstream.
- Walks the enabled channels (i0..i3) in ascending order, holds each select for a settle interval, then samples `f`.
- Assembles the four sampled values into a 4-bit result word and signals completion with a handshake.
- Used wherever the design needs a snapshot of all mux inputs through a single observation point.

Parameters:
- SETTLE, default 2: cycles the selects are held stable before sampling. Legal range 1..15.
- CNT_W, default 4: width of the settle down-counter. Must satisfy 2^CNT_W > SETTLE.

Ports:
- clk        input   1  single system clock; all state updates on its rising edge
- rst_n      input   1  asynchronous, active-low reset
- start      input   1  scan request; sampled only in IDLE
- abort      input   1  synchronous cancel of an in-progress scan
- ch_mask    input   4  channel enable; bit k enables channel k; latched on an accepted start
- f          input   1  mux output under observation
- s0         output  1  mux select LSB (registered)
- s1         output  1  mux select MSB (registered)
- busy       output  1  high from the cycle after an accepted start until the scan ends
- done       output  1  one-cycle pulse when a scan completes normally
- sample     output  4  bit k = value of `f` captured while channel k was selected
- valid_mask output  4  copy of the latched ch_mask for the scan; qualifies `sample`

Behaviour:
- Reset (rst_n=0, asynchronous):
  - State = IDLE.
  - s1, s0, busy, done = 0.
  - sample, valid_mask = 4'b0000.
  - Settle counter = 0.
  - Applies immediately, including mid-scan. No done pulse is produced for a scan cut short by reset.
- States: IDLE, SETTLE, SAMPLE, DONE.
- IDLE:
  - s1s0 = 00, busy = 0.
  - start=1 with ch_mask≠0:
    - Latch ch_mask into valid_mask and clear sample.
    - Load the first enabled channel (lowest set bit) onto s1s0.
    - Load counter = SETTLE-1 and go to SETTLE.
  - start=1 with ch_mask=0:
    - Latch valid_mask = 0, clear sample, go directly to DONE.
- SETTLE:
  - busy = 1 and the selects are held.
  - Counter decrements each cycle; at 0, go to SAMPLE.
  - Total time in SETTLE per channel = SETTLE cycles.
- SAMPLE (one cycle):
  - sample[ch] <= f at the end of the cycle; selects are still held.
  - If a higher enabled channel exists, load it onto s1s0, reload the counter, and go to SETTLE.
  - Otherwise go to DONE.
  - Disabled channels consume zero cycles. The selects jump directly from one enabled channel to the next.
- DONE (one cycle):
  - done = 1, busy = 0, s1s0 = 00.
  - Next state is IDLE; a start asserted during DONE is ignored.
  - sample and valid_mask hold until the next accepted start or reset.
- Latency:
  - Start accepted at edge 0; busy is high from cycle 1.
  - done is high in cycle N*(SETTLE+1)+1, where N = popcount(ch_mask).
  - Example: N=4, SETTLE=2 gives done in cycle 13.
- start while busy: ignored. ch_mask changes during a scan: no effect.
- abort=1 in SETTLE or SAMPLE:
  - Next state is IDLE and s1s0 = 00.
  - No done pulse; no capture in that cycle.
  - sample keeps any bits already captured; valid_mask is cleared to 0 so partial data is never qualified.
  - abort in IDLE or DONE: no effect.
- abort and start together in IDLE: start wins, since abort has no effect in IDLE.
- `f` comes from combinational logic on registered selects, so no synchroniser is used. An x on `f` is captured as-is and not filtered.

Decomposition:
- Package mux_scan_pkg holds:
  - The state enum (IDLE, SETTLE, SAMPLE, DONE).
  - Constants N_CH=4 and SEL_W=2.
  - A channel-index typedef of width SEL_W.
- Sub-module mux_scan_next_ch (purely combinational) takes the 4-bit mask and the current channel plus a "from start" flag. It returns:
  - The next enabled channel index strictly above the current one (or the lowest enabled, when from start).
  - A `found` flag.
- The top block instantiates mux_scan_next_ch once and contains the FSM, counter and result registers.

Test Plan:
- Full scan: SETTLE=2, i0..i3 = 1,0,1,1, ch_mask=1111, start pulse → s1s0 sequence 00,01,10,11, each held 3 cycles; done in cycle 13; sample=1101, valid_mask=1111.
- Sparse mask: ch_mask=1010, inputs i1=1, i3=0 → selects visit only 01 then 11; done in cycle 7; sample=0010, valid_mask=1010.
- Empty mask: ch_mask=0000, start → busy never high; done in cycle 1; sample=0000, valid_mask=0000.
- Abort: full mask, abort in cycle 5 (channel 1 in SETTLE) → IDLE next cycle; s1s0=00; no done; sample[0] retained; valid_mask=0000; a following start runs normally.
- Reset mid-scan: drop rst_n in cycle 8 → s1, s0, busy, done, sample and valid_mask are all 0 immediately, with no clock edge needed; release, start → normal full scan.
- Start while busy / during DONE: extra start pulses in cycles 3 and 13 → ignored; exactly one done pulse; s1s0 sequence unchanged.
